// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - multi-cycle A - B - borrowin, one CHUNK-bit slice per clock
module serial_ripple_subtractor #(
    parameter int NUMBITS = 8,
    parameter int CHUNK   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               borrowin,
    output logic               busy,
    output logic               done,
    output logic [NUMBITS-1:0] result,
    output logic               borrowout,
    output logic               overflow
);

    localparam int C    = NUMBITS / CHUNK;
    localparam int IDXW = (C > 1) ? $clog2(C) : 1;
    localparam int MSB  = NUMBITS - 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(C - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUMBITS-1:0] a_q, a_d;
    logic [NUMBITS-1:0] b_q, b_d;
    logic [NUMBITS-1:0] result_q, result_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic               borrow_q, borrow_d;
    logic               borrowout_q, borrowout_d;
    logic               overflow_q, overflow_d;

    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic [CHUNK:0]     diff;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        borrowout_d = borrowout_q;
        overflow_d  = overflow_q;

        a_slice = a_q[idx_q*CHUNK +: CHUNK];
        b_slice = b_q[idx_q*CHUNK +: CHUNK];
        diff    = {1'b0, a_slice} - {1'b0, b_slice} - {{CHUNK{1'b0}}, borrow_q};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d         = A;
                    b_d         = B;
                    borrow_d    = borrowin;
                    idx_d       = '0;
                    borrowout_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[idx_q*CHUNK +: CHUNK] = diff[CHUNK-1:0];
                borrow_d = diff[CHUNK];
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Flags are latched with the last slice so they hold until the next start.
                    state_d     = DONE;
                    borrowout_d = diff[CHUNK];
                    overflow_d  = (a_q[MSB] ^ b_q[MSB]) & (result_d[MSB] ^ a_q[MSB]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            borrowout_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            borrowout_q <= borrowout_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign borrowout = borrowout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb/tb_serial_ripple_subtractor.sv - directed checks of serial_ripple_subtractor at 8/4 and 128/4
module tb_serial_ripple_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start;
    logic [7:0]   a, b;
    logic         bi;
    logic         busy, done;
    logic [7:0]   result;
    logic         bo, ov;

    logic         start_w;
    logic [127:0] a_w, b_w;
    logic         bi_w;
    logic         busy_w, done_w;
    logic [127:0] result_w;
    logic         bo_w, ov_w;

    int passed = 0;
    int total  = 0;

    serial_ripple_subtractor #(.NUMBITS(8), .CHUNK(4)) dut8 (
        .clk(clk), .reset(reset), .start(start), .A(a), .B(b), .borrowin(bi),
        .busy(busy), .done(done), .result(result), .borrowout(bo), .overflow(ov)
    );

    serial_ripple_subtractor #(.NUMBITS(128), .CHUNK(4)) dut128 (
        .clk(clk), .reset(reset), .start(start_w), .A(a_w), .B(b_w), .borrowin(bi_w),
        .busy(busy_w), .done(done_w), .result(result_w), .borrowout(bo_w), .overflow(ov_w)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] res;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one 8-bit operation; returns at the negedge where done is seen (or on timeout).
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ibi,
                        output int lat, output int bcnt);
        @(negedge clk);
        a = ia; b = ib; bi = ibi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 50) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt;
        logic seen;

        vecs[0] = '{8'h16, 8'h0B, 1'b0, 8'h0B, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[7] = '{8'h50, 8'h30, 1'b1, 8'h1F, 1'b0, 1'b0};

        reset = 1'b0; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        start_w = 1'b0; a_w = '0; b_w = '0; bi_w = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_borrowout", bo, 1'b0);
        chk("rst_overflow", ov, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].bi, lat, bcnt);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, 2);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_borrowout", i), bo, vecs[i].bo);
            chk($sformatf("v%0d_overflow", i), ov, vecs[i].ov);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
            chk($sformatf("v%0d_result_hold", i), result, vecs[i].res);
        end

        // start pulsed while RUN, with new operands, must be ignored
        @(negedge clk);
        a = 8'h16; b = 8'h0B; bi = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h00; bi = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_done", done, 1'b1);
        chk("ign_result", result, 8'h0B);
        @(negedge clk);
        chk("ign_no_restart", busy, 1'b0);
        chk("ign_result_hold", result, 8'h0B);

        // back-to-back: start held high across two operations
        @(negedge clk);
        a = 8'h16; b = 8'h0B; bi = 1'b0; start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 50) begin @(negedge clk); lat++; end
        chk("b2b_lat1", lat, 3);
        chk("b2b_result1", result, 8'h0B);
        a = 8'h80; b = 8'h01;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 50) begin @(negedge clk); lat++; end
        chk("b2b_lat2", lat, 3);
        chk("b2b_result2", result, 8'h7F);
        chk("b2b_overflow2", ov, 1'b1);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_idle", busy | done, 1'b0);

        // reset asserted at slice 1 aborts immediately
        @(negedge clk);
        a = 8'h00; b = 8'h01; bi = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, 8'h00);
        chk("abort_borrowout", bo, 1'b0);
        chk("abort_overflow", ov, 1'b0);
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (done) seen = 1'b1; end
        chk("abort_no_done", seen, 1'b0);
        reset = 1'b1;
        run8(8'h80, 8'h01, 1'b0, lat, bcnt);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_result", result, 8'h7F);
        chk("post_rst_overflow", ov, 1'b1);
        @(negedge clk);

        // 128-bit instance: borrow ripples through all 32 slices
        @(negedge clk);
        a_w = '0; b_w = 128'd1; bi_w = 1'b0; start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        lat = 1;
        while (!done_w && lat < 100) begin @(negedge clk); lat++; end
        chk("w128_latency", lat, 33);
        chk("w128_result", result_w, {128{1'b1}});
        chk("w128_borrowout", bo_w, 1'b1);
        chk("w128_overflow", ov_w, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_ripple_subtractor.md
# serial_ripple_subtractor

Multi-cycle subtractor computing A − B − borrowin over NUMBITS bits, one CHUNK-bit slice per clock, with the borrow registered between slices. It is the subtracting counterpart of the combinational ripple-carry adder: it trades latency for a short per-cycle borrow chain at wide widths (64/128). It sits behind a start/done handshake so an ALU sequencer can issue one operation and poll for completion.

## Interface
- NUMBITS, 8, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 4, bits processed per cycle; C = NUMBITS/CHUNK slice cycles per operation
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-low
- start  input  1  request; sampled only when idle or done
- A  input  NUMBITS  minuend; captured on accepted start
- B  input  NUMBITS  subtrahend; captured on accepted start
- borrowin  input  1  initial borrow; captured on accepted start
- busy  output  1  high while slices are being computed
- done  output  1  one-cycle pulse: result/flags valid
- result  output  NUMBITS  A − B − borrowin mod 2^NUMBITS
- borrowout  output  1  1 iff A < B + borrowin (unsigned)
- overflow  output  1  two's-complement overflow of the subtraction

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE and clears busy, done, result, borrowout, overflow, the slice index and the borrow register to 0.
- IDLE: start=1 at a rising edge captures A, B, borrowin into internal registers, clears slice index to 0, enters RUN. start=0 holds IDLE.
- RUN (busy=1): each edge computes slice i (bits i*CHUNK+CHUNK-1 .. i*CHUNK): {b, d} = a_i − b_i − borrow_reg, using a (CHUNK+1)-bit subtraction. d is written into that slice of the result register, b into borrow_reg, i increments. After slice C−1 is written, enter DONE.
- DONE (done=1, busy=0): borrowout = final borrow_reg; overflow = (A[MSB] ≠ B[MSB]) and (result[MSB] ≠ A[MSB]), using captured operands. Next edge: start=1 → accept new operation exactly as IDLE (back-to-back); else → IDLE.
- result, borrowout, overflow hold their values after DONE until the next accepted start; slices of result are undefined to the consumer while busy (they update progressively).
- start while RUN: ignored; no recapture, no effect on the running operation.
- Changes on A/B/borrowin after capture have no effect.
- Widths: all slice arithmetic is unsigned modulo 2^CHUNK; no sign extension anywhere except the overflow check.

## Timing
- start accepted at edge 0 → busy high from edge 0 through edge C (C cycles) → done high for the single cycle after edge C → total latency C+1 edges from accepted start to done observed.
- NUMBITS=8, CHUNK=4: done in cycle 3 after start edge; NUMBITS=128, CHUNK=4: C=32, done after 33 edges.
- Back-to-back: start held high continuously yields one operation every C+1 cycles.
- reset asserted mid-RUN: immediate abort, all outputs 0 asynchronously, done never pulses for that operation; first start after reset release behaves as from IDLE.
- reset released and start high on the same edge: start is accepted only on an edge where reset is already deasserted.

## Test plan
- 8/4: A=0x16, B=0x0B, borrowin=0 → done after 3 edges, result=0x0B, borrowout=0, overflow=0; busy high exactly 2 cycles.
- 8/4: A=0x00, B=0x01 → result=0xFF, borrowout=1, overflow=0; A=0x80, B=0x01 → result=0x7F, borrowout=0, overflow=1.
- 8/4: A=0x00, B=0x00, borrowin=1 → result=0xFF, borrowout=1; A=0xFF, B=0xFF, borrowin=0 → result=0x00, borrowout=0 (borrow propagation across slice boundary checked).
- 128/4: A=0, B=1 → result=all-F, borrowout=1, done exactly 33 edges after start; 16/32/64 widths same operands, done at C+1.
- Pulse start again 1 cycle into RUN with different A/B → ignored, first result unchanged; then hold start high for two operations → second done exactly C+1 cycles after first.
- Assert reset at RUN slice 1 → busy/done/result/borrowout/overflow read 0 immediately, no done pulse; new start after release gives correct result with normal latency.
